// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the instruction fetch stage and its fetch-to-decode
// bus: the bus packet layout, the fetch FSM state encoding and address
// constants.
// -----------------------------------------------------------------------------
package cpu_pkg;

   // Byte stride between consecutive instructions.
   localparam int unsigned INSN_BYTES = 4;

   // Default PC loaded on reset (must be 4-byte aligned).
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   // Packet handed to decode; pc occupies the upper half of the flat bus.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] insn;
   } FetchToDecodeBusPacket;

   typedef enum logic [1:0] {
      REQ   = 2'd0,
      WAIT  = 2'd1,
      SEND  = 2'd2,
      DRAIN = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch: holds the PC, issues one instruction-memory read at a
// time, captures the returned word and hands {pc, insn} to the one-slot
// fetch-to-decode mailbox. Redirects from later stages squash any in-flight
// or pending fetch.
//
// Ports
//   clk, reset_n        clock, synchronous active-low reset
//   mem_req_valid/addr  read request (address = current PC)
//   mem_req_ready       memory accepts the request this cycle
//   mem_resp_valid/data one-cycle response pulse with the instruction word
//   bus_is_busy         mailbox occupied
//   send_valid/pkt      one-cycle pulse; mailbox captures send_pkt {pc, insn}
//   redirect_valid/pc   redirect request; low two target bits are ignored
//   insn_count          packets sent so far (wraps)
// -----------------------------------------------------------------------------
module fetch_stage
   import cpu_pkg::*;
#(
   parameter int unsigned          ADDR_W   = 32,
   parameter int unsigned          INSN_W   = 32,
   parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
   input  logic                       clk,
   input  logic                       reset_n,
   output logic                       mem_req_valid,
   output logic [ADDR_W-1:0]          mem_req_addr,
   input  logic                       mem_req_ready,
   input  logic                       mem_resp_valid,
   input  logic [INSN_W-1:0]          mem_resp_data,
   input  logic                       bus_is_busy,
   output logic                       send_valid,
   output logic [ADDR_W+INSN_W-1:0]   send_pkt,
   input  logic                       redirect_valid,
   input  logic [ADDR_W-1:0]          redirect_pc,
   output logic [31:0]                insn_count
);

   fetch_state_t                state_q, state_d;
   logic [ADDR_W-1:0]           pc_q, pc_d;
   logic [ADDR_W+INSN_W-1:0]    pkt_q, pkt_d;
   logic [31:0]                 count_q, count_d;
   logic [ADDR_W-1:0]           redirect_tgt;

   assign redirect_tgt = {redirect_pc[ADDR_W-1:2], 2'b00};

   // Next-state and output decode. The request side depends only on state;
   // the send pulse additionally honours the mailbox handshake and is killed
   // by a same-cycle redirect so a squashed packet never reaches decode.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      pkt_d         = pkt_q;
      count_d       = count_q;
      mem_req_valid = reset_n && (state_q == REQ);
      mem_req_addr  = pc_q;
      send_pkt      = pkt_q;
      send_valid    = reset_n && (state_q == SEND) && !bus_is_busy && !redirect_valid;

      unique case (state_q)
         REQ: begin
            if (redirect_valid) begin
               pc_d = redirect_tgt;
               // The old address may already have been accepted; its
               // response must be swallowed before re-issuing.
               state_d = mem_req_ready ? DRAIN : REQ;
            end else if (mem_req_ready) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (redirect_valid) begin
               pc_d    = redirect_tgt;
               state_d = mem_resp_valid ? REQ : DRAIN;
            end else if (mem_resp_valid) begin
               pkt_d   = {pc_q, mem_resp_data};
               state_d = SEND;
            end
         end
         SEND: begin
            if (redirect_valid) begin
               pc_d    = redirect_tgt;
               state_d = REQ;
            end else if (!bus_is_busy) begin
               pc_d    = pc_q + ADDR_W'(INSN_BYTES);
               count_d = count_q + 32'd1;
               state_d = REQ;
            end
         end
         DRAIN: begin
            // A redirect here only retargets the PC; the stale response is
            // still owed and ends the drain when it arrives.
            if (redirect_valid) pc_d = redirect_tgt;
            if (mem_resp_valid) state_d = REQ;
         end
         default: state_d = REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= REQ;
         pc_q    <= RESET_PC;
         pkt_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pkt_q   <= pkt_d;
         count_q <= count_d;
      end
   end

   assign insn_count = count_q;

`ifndef SYNTHESIS
   // A response is only legal while a request is outstanding.
   always_ff @(posedge clk) begin
      if (reset_n && mem_resp_valid)
         assert (state_q == WAIT || state_q == DRAIN)
            else $error("fetch_stage: memory response with no outstanding request");
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage. Inputs change just after the falling edge;
// outputs are sampled 1 time unit later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic        mem_req_ready;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        bus_is_busy;
   logic        send_valid;
   logic [63:0] send_pkt;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] insn_count;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;

   fetch_stage dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .mem_req_valid  (mem_req_valid),
      .mem_req_addr   (mem_req_addr),
      .mem_req_ready  (mem_req_ready),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .bus_is_busy    (bus_is_busy),
      .send_valid     (send_valid),
      .send_pkt       (send_pkt),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .insn_count     (insn_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic step();
      @(negedge clk);
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = 32'h0;
      bus_is_busy    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      step();
      #1;
      total++;
      if (mem_req_valid !== 1'b0 || send_valid !== 1'b0)
         $display("FAIL reset_gating: req_valid=%b send_valid=%b, required 0/0", mem_req_valid, send_valid);
      else passed++;
      step();
      reset_n = 1'b1;
      #1;
      total++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0)
         $display("FAIL reset_req: valid=%b addr=%h, required 1/00000000", mem_req_valid, mem_req_addr);
      else passed++;
      total++;
      if (insn_count !== 32'd0 || send_valid !== 1'b0)
         $display("FAIL reset_count: count=%0d send=%b, required 0/0", insn_count, send_valid);
      else passed++;
   endtask

   // Two fetches through a 1-cycle memory with a free bus.
   task automatic test_basic();
      logic [31:0] words [2] = '{32'h1111_1111, 32'h2222_2222};
      int send_cyc [2];
      for (int i = 0; i < 2; i++) begin
         // REQ: address must be the sequential PC
         total++;
         if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'(i * 4))
            $display("FAIL basic_req%0d: valid=%b addr=%h, required 1/%h", i, mem_req_valid, mem_req_addr, 32'(i * 4));
         else passed++;
         mem_req_ready = 1'b1;
         step();
         mem_resp_valid = 1'b1;
         mem_resp_data  = words[i];
         #1;
         total++;
         if (mem_req_valid !== 1'b0 || send_valid !== 1'b0)
            $display("FAIL basic_wait%0d: req_valid=%b send_valid=%b, required 0/0", i, mem_req_valid, send_valid);
         else passed++;
         step();
         #1;
         send_cyc[i] = cyc;
         total++;
         if (send_valid !== 1'b1 || send_pkt !== {32'(i * 4), words[i]})
            $display("FAIL basic_send%0d: valid=%b pkt=%h, required 1/%h", i, send_valid, send_pkt, {32'(i * 4), words[i]});
         else passed++;
         step();
         #1;
      end
      total++;
      if (send_cyc[1] - send_cyc[0] != 3)
         $display("FAIL basic_spacing: %0d cycles, required 3", send_cyc[1] - send_cyc[0]);
      else passed++;
      total++;
      if (insn_count !== 32'd2 || mem_req_addr !== 32'h8)
         $display("FAIL basic_count: count=%0d addr=%h, required 2/00000008", insn_count, mem_req_addr);
      else passed++;
   endtask

   task automatic test_busy();
      mem_req_ready = 1'b1;
      step();
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'h3333_3333;
      step();
      for (int i = 0; i < 5; i++) begin
         bus_is_busy = 1'b1;
         #1;
         total++;
         if (send_valid !== 1'b0 || send_pkt !== {32'h8, 32'h3333_3333} || mem_req_valid !== 1'b0)
            $display("FAIL busy_hold%0d: send=%b pkt=%h req=%b, required 0/%h/0", i, send_valid, send_pkt, mem_req_valid, {32'h8, 32'h3333_3333});
         else passed++;
         step();
      end
      #1;
      total++;
      if (send_valid !== 1'b1 || send_pkt !== {32'h8, 32'h3333_3333})
         $display("FAIL busy_release: send=%b pkt=%h, required 1/%h", send_valid, send_pkt, {32'h8, 32'h3333_3333});
      else passed++;
      step();
      #1;
      total++;
      if (send_valid !== 1'b0 || mem_req_addr !== 32'hC || insn_count !== 32'd3)
         $display("FAIL busy_after: send=%b addr=%h count=%0d, required 0/0000000c/3", send_valid, mem_req_addr, insn_count);
      else passed++;
   endtask

   task automatic test_redirect_wait();
      mem_req_ready = 1'b1;
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h103;
      step();
      // Late response for the squashed fetch.
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'h0000_DEAD;
      #1;
      total++;
      if (send_valid !== 1'b0 || mem_req_valid !== 1'b0)
         $display("FAIL rw_drain: send=%b req=%b, required 0/0", send_valid, mem_req_valid);
      else passed++;
      step();
      #1;
      total++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100 || send_valid !== 1'b0)
         $display("FAIL rw_newreq: req=%b addr=%h send=%b, required 1/00000100/0", mem_req_valid, mem_req_addr, send_valid);
      else passed++;
      mem_req_ready = 1'b1;
      step();
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'h4444_4444;
      step();
      #1;
      total++;
      if (send_valid !== 1'b1 || send_pkt !== {32'h100, 32'h4444_4444})
         $display("FAIL rw_send: send=%b pkt=%h, required 1/%h", send_valid, send_pkt, {32'h100, 32'h4444_4444});
      else passed++;
      step();
   endtask

   task automatic test_redirect_send();
      mem_req_ready = 1'b1;
      step();
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'h5555_5555;
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      #1;
      total++;
      if (send_valid !== 1'b0)
         $display("FAIL rs_pulse: send=%b, required 0", send_valid);
      else passed++;
      step();
      #1;
      total++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h200 || insn_count !== 32'd4)
         $display("FAIL rs_after: req=%b addr=%h count=%0d, required 1/00000200/4", mem_req_valid, mem_req_addr, insn_count);
      else passed++;
   endtask

   task automatic test_redirect_req();
      // Redirect coincides with acceptance of the old address.
      mem_req_ready  = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h300;
      #1;
      total++;
      if (mem_req_addr !== 32'h200)
         $display("FAIL rq_oldaddr: addr=%h, required 00000200", mem_req_addr);
      else passed++;
      step();
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'h0000_0BAD;
      #1;
      total++;
      if (mem_req_valid !== 1'b0 || send_valid !== 1'b0)
         $display("FAIL rq_drain: req=%b send=%b, required 0/0", mem_req_valid, send_valid);
      else passed++;
      step();
      #1;
      total++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h300)
         $display("FAIL rq_newreq: req=%b addr=%h, required 1/00000300", mem_req_valid, mem_req_addr);
      else passed++;
      // Redirect in REQ without acceptance: stay REQ, low bits cleared.
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFF;
      step();
      #1;
      total++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'hFFFF_FFFC)
         $display("FAIL rq_noacc: req=%b addr=%h, required 1/fffffffc", mem_req_valid, mem_req_addr);
      else passed++;
   endtask

   task automatic test_pc_wrap();
      mem_req_ready = 1'b1;
      step();
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'h6666_6666;
      step();
      #1;
      total++;
      if (send_valid !== 1'b1 || send_pkt !== {32'hFFFF_FFFC, 32'h6666_6666})
         $display("FAIL wrap_send: send=%b pkt=%h, required 1/%h", send_valid, send_pkt, {32'hFFFF_FFFC, 32'h6666_6666});
      else passed++;
      step();
      #1;
      total++;
      if (mem_req_addr !== 32'h0 || insn_count !== 32'd5)
         $display("FAIL wrap_pc: addr=%h count=%0d, required 00000000/5", mem_req_addr, insn_count);
      else passed++;
   endtask

   task automatic test_reset_in_wait();
      mem_req_ready = 1'b1;
      step();
      reset_n = 1'b0;
      #1;
      total++;
      if (mem_req_valid !== 1'b0 || send_valid !== 1'b0)
         $display("FAIL rst_wait_gate: req=%b send=%b, required 0/0", mem_req_valid, send_valid);
      else passed++;
      step();
      reset_n = 1'b1;
      #1;
      total++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0 || insn_count !== 32'd0 || send_valid !== 1'b0)
         $display("FAIL rst_wait_after: req=%b addr=%h count=%0d send=%b, required 1/00000000/0/0", mem_req_valid, mem_req_addr, insn_count, send_valid);
      else passed++;
   endtask

   initial begin
      reset_n        = 1'b0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = 32'h0;
      bus_is_busy    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      test_reset();
      test_basic();
      test_busy();
      test_redirect_wait();
      test_redirect_send();
      test_redirect_req();
      test_pc_wrap();
      test_reset_in_wait();
      step();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
